cvtcolor_rgb2gray_pipe: RTL and testbench

Pipelined RGB888-to-8-bit-luma converter in the cvtcolor component. Sits directly downstream of the pixel unpacker and directly upstream of the gray-frame writer. Computes BT.601 luma with three 16×16 unsigned multiplies, a rounded sum and saturation, behind an AXI4-Stream-style valid/ready handshake. Also checks line length on the input side.

---
 rtl/cvtcolor_pkg.sv | 23 ++
 rtl/cvtcolor_gray_mul_stage.sv | 20 ++
 rtl/cvtcolor_rgb2gray_pipe.sv | 138 +++++++++++++
 tb/tb_cvtcolor_rgb2gray_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cvtcolor_pkg.sv
// Shared types and constants for the cvtcolor RGB-to-gray path.
// Coefficients are BT.601 luma weights in Q0.16.
package cvtcolor_pkg;

  localparam logic [15:0] BT601_COEF_R = 16'd19595;
  localparam logic [15:0] BT601_COEF_G = 16'd38470;
  localparam logic [15:0] BT601_COEF_B = 16'd7471;
  localparam logic [33:0] ROUND_HALF   = 34'd32768;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pixel_t;

  typedef logic [7:0] luma_t;

  // Any weight above 1.0 can push the rounded sum past 8 integer bits; clamp it.
  function automatic luma_t saturate_luma(input logic [33:0] sum);
    return (|sum[33:24]) ? 8'hFF : sum[23:16];
  endfunction

endpackage

// File: rtl/cvtcolor_gray_mul_stage.sv
// 16x16 unsigned multiplier with a registered 32-bit product.
// The product register holds while the clock enable is low.
module cvtcolor_gray_mul_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (ce) begin
      p <= 32'(a) * 32'(b);
    end
  end

endmodule

// File: rtl/cvtcolor_rgb2gray_pipe.sv
// Three-stage RGB888 to 8-bit luma pipeline with AXIS-style handshake
// and input-side line-length checking.
module cvtcolor_rgb2gray_pipe
  import cvtcolor_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 1920,
  parameter logic [15:0] COEF_R    = BT601_COEF_R,
  parameter logic [15:0] COEF_G    = BT601_COEF_G,
  parameter logic [15:0] COEF_B    = BT601_COEF_B
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic [23:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tuser,
  input  logic        s_tlast,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        err_short,
  output logic        err_long,
  input  logic        err_clr
);

  localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);

  logic        ce;
  logic        accept;
  logic        s1_valid, s1_user, s1_last;
  logic        s2_valid, s2_user, s2_last;
  rgb_pixel_t  s1_pix;
  logic [31:0] prod_r, prod_g, prod_b;
  logic [33:0] sum;
  logic [15:0] col, beat_col;
  logic        short_hit, long_hit;

  // One global enable: the whole pipe freezes only when the output is held.
  assign ce       = !m_tvalid || m_tready;
  assign s_tready = ce;
  assign accept   = s_tvalid && ce;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_user  <= 1'b0;
      s1_last  <= 1'b0;
    end else if (ce) begin
      s1_valid <= s_tvalid;
      s1_pix   <= s_tdata;
      s1_user  <= s_tuser;
      s1_last  <= s_tlast;
    end
  end

  cvtcolor_gray_mul_stage u_mul_r (
    .clk(ap_clk), .rst_n(ap_rst_n), .ce(ce),
    .a({8'd0, s1_pix.r}), .b(COEF_R), .p(prod_r)
  );
  cvtcolor_gray_mul_stage u_mul_g (
    .clk(ap_clk), .rst_n(ap_rst_n), .ce(ce),
    .a({8'd0, s1_pix.g}), .b(COEF_G), .p(prod_g)
  );
  cvtcolor_gray_mul_stage u_mul_b (
    .clk(ap_clk), .rst_n(ap_rst_n), .ce(ce),
    .a({8'd0, s1_pix.b}), .b(COEF_B), .p(prod_b)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s2_valid <= 1'b0;
      s2_user  <= 1'b0;
      s2_last  <= 1'b0;
    end else if (ce) begin
      s2_valid <= s1_valid;
      s2_user  <= s1_user;
      s2_last  <= s1_last;
    end
  end

  assign sum = {2'b00, prod_r} + {2'b00, prod_g} + {2'b00, prod_b} + ROUND_HALF;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tuser  <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (ce) begin
      m_tvalid <= s2_valid;
      m_tdata  <= saturate_luma(sum);
      m_tuser  <= s2_user;
      m_tlast  <= s2_last;
    end
  end

  // A start-of-frame beat is column 0 regardless of where the counter was.
  assign beat_col  = s_tuser ? 16'd0 : col;
  assign short_hit = accept && s_tlast && (beat_col != LAST_COL);
  assign long_hit  = accept && !s_tlast && (beat_col == LAST_COL);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      col <= '0;
    end else if (accept) begin
      if (s_tuser) begin
        col <= 16'd1;
      end else if (s_tlast || col == LAST_COL) begin
        col <= '0;
      end else begin
        col <= col + 16'd1;
      end
    end
  end

  // Set takes priority over a same-cycle clear so no event is lost.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      if (short_hit) begin
        err_short <= 1'b1;
      end else if (err_clr) begin
        err_short <= 1'b0;
      end
      if (long_hit) begin
        err_long <= 1'b1;
      end else if (err_clr) begin
        err_long <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cvtcolor_rgb2gray_pipe.sv
// Self-checking bench for cvtcolor_rgb2gray_pipe: directed steps plus random
// traffic, scored against an arithmetic luma model and a beat queue.
module tb_cvtcolor_rgb2gray_pipe;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [23:0] s_tdata;
  logic        s_tvalid, s_tready, s_tuser, s_tlast;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tuser, m_tlast;
  logic        err_short, err_long, err_clr;

  cvtcolor_rgb2gray_pipe #(.IMG_WIDTH(4)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tuser(s_tuser), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tuser(m_tuser), .m_tlast(m_tlast),
    .err_short(err_short), .err_long(err_long), .err_clr(err_clr)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic user;
    logic last;
    int   luma;
    int   acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   next_exp  = -1;
  int   tready_mode = 0;
  bit   check_latency = 0;
  bit   last_accepted = 0;
  bit   was_stalled = 0;
  logic [7:0] held_data;

  // BT.601 luma straight from the weights: round to nearest, clamp at 255.
  function automatic int ref_luma(input logic [23:0] px);
    longint s;
    s = longint'(px[23:16]) * 19595 + longint'(px[15:8]) * 38470
      + longint'(px[7:0]) * 7471 + 32768;
    s = s >>> 16;
    return (s > 255) ? 255 : int'(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe the pre-edge state at the falling edge, then advance.
  task automatic tick();
    exp_t e;
    if (tready_mode == 1) m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    else if (tready_mode == 2) m_tready = ($urandom % 3) != 0;
    @(negedge ap_clk);
    check("s_tready", s_tready, !(m_tvalid && !m_tready));
    if (was_stalled) begin
      check("hold_data", m_tdata, held_data);
      check("hold_valid", m_tvalid, 1'b1);
    end
    was_stalled = m_tvalid && !m_tready;
    held_data   = m_tdata;
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("stale_out", m_tvalid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("m_tdata", m_tdata, e.luma);
        check("m_tuser", m_tuser, e.user);
        check("m_tlast", m_tlast, e.last);
        if (check_latency) check("latency", cyc - e.acc, 3);
      end
    end
    last_accepted = s_tvalid && s_tready;
    if (last_accepted) begin
      e.user = s_tuser;
      e.last = s_tlast;
      e.luma = (next_exp >= 0) ? next_exp : ref_luma(s_tdata);
      e.acc  = cyc;
      exp_q.push_back(e);
    end
    @(posedge ap_clk);
    cyc++;
    #1;
  endtask

  // Offer one beat and hold it until the pipeline takes it.
  task automatic send(input logic [23:0] px, input logic user, input logic last, input int exp_val);
    int guard;
    s_tdata  = px;
    s_tuser  = user;
    s_tlast  = last;
    s_tvalid = 1'b1;
    next_exp = exp_val;
    guard    = 0;
    do begin
      tick();
      guard++;
    end while (!last_accepted && guard < 50);
    if (!last_accepted) check("send_timeout", last_accepted, 1'b1);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    next_exp = -1;
  endtask

  task automatic drain();
    int guard;
    m_tready    = 1'b1;
    tready_mode = 0;
    guard       = 0;
    while ((exp_q.size() != 0 || m_tvalid) && guard < 50) begin
      tick();
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_short", err_short, 1'b0);
    check("clr_long", err_long, 1'b0);
  endtask

  initial begin
    ap_rst_n = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    err_clr  = 1'b0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tdata", m_tdata, 8'd0);
    check("rst_m_tuser", m_tuser, 1'b0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_err_short", err_short, 1'b0);
    check("rst_err_long", err_long, 1'b0);
    check("rst_s_tready", s_tready, 1'b1);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    // Line-length checking with a 4-pixel line width.
    for (int i = 0; i < 4; i++) send(24'($urandom), 1'b0, i == 3, -1);
    check("line4_short", err_short, 1'b0);
    check("line4_long", err_long, 1'b0);
    for (int i = 0; i < 3; i++) send(24'($urandom), 1'b0, i == 2, -1);
    check("line3_short", err_short, 1'b1);
    check("line3_long", err_long, 1'b0);
    clear_errors();
    for (int i = 0; i < 3; i++) send(24'($urandom), 1'b0, 1'b0, -1);
    check("line5_pre_long", err_long, 1'b0);
    send(24'($urandom), 1'b0, 1'b0, -1);
    check("line5_long", err_long, 1'b1);
    check("line5_short", err_short, 1'b0);
    send(24'($urandom), 1'b0, 1'b1, -1);
    drain();
    clear_errors();

    // Known luma values, back to back, with fixed 3-cycle latency.
    check_latency = 1;
    send(24'hFFFFFF, 1'b0, 1'b0, 255);
    send(24'h808080, 1'b0, 1'b0, 128);
    send(24'h000000, 1'b0, 1'b0, 0);
    send(24'hFF0000, 1'b0, 1'b0, 76);
    send(24'h00FF00, 1'b0, 1'b0, 150);
    send(24'h0000FF, 1'b0, 1'b0, 29);
    drain();

    // Start-of-frame on the third pixel realigns the column count.
    clear_errors();
    for (int i = 0; i < 6; i++) send(24'($urandom), (i == 0) || (i == 2), i == 5, -1);
    drain();
    check("resync_short", err_short, 1'b0);
    check("resync_long", err_long, 1'b0);
    check_latency = 0;

    // Output stalls with a 1,0,0,1 ready pattern.
    tready_mode = 1;
    for (int i = 0; i < 8; i++) send(24'($urandom), i == 0, (i % 4) == 3, -1);
    drain();

    // Random traffic: random gaps, random backpressure, 4-pixel lines.
    tready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom % 3) tick();
      send(24'($urandom), (i % 4) == 0, (i % 4) == 3, -1);
    end
    drain();
    check("rand_short", err_short, 1'b0);
    check("rand_long", err_long, 1'b0);

    // Reset with three pixels in flight, mid-line.
    for (int i = 0; i < 3; i++) send(24'($urandom), 1'b0, 1'b0, -1);
    check("inflight_valid", m_tvalid, 1'b1);
    #2 ap_rst_n = 1'b0;
    #1;
    check("async_rst_valid", m_tvalid, 1'b0);
    check("async_rst_ready", s_tready, 1'b1);
    exp_q.delete();
    was_stalled = 0;
    @(posedge ap_clk);
    #3 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    repeat (4) tick();
    check_latency = 1;
    for (int i = 0; i < 4; i++) send(24'($urandom), 1'b0, i == 3, -1);
    drain();
    check("post_rst_short", err_short, 1'b0);
    check("post_rst_long", err_long, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
